// File: rtl/decode_execute_stage.sv
// Decode/execute pipeline register with load-use bubble insertion,
// flush/stall handling and a saturating lost-cycle counter.
module decode_execute_stage #(
    parameter int WIDTH = 32,
    parameter int ADDR  = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Branch_D,
    input  logic             MemtoReg_D,
    input  logic             MemW_D,
    input  logic             ALUSrc_D,
    input  logic             RegW_D,
    input  logic             ALUOp_D,
    input  logic [2:0]       Opcode_D,
    input  logic             V_D,
    input  logic [2:0]       Funct_D,
    input  logic             valid_D,
    input  logic [WIDTH-1:0] RD1_D,
    input  logic [WIDTH-1:0] RD2_D,
    input  logic [WIDTH-1:0] ExtImm_D,
    input  logic [ADDR-1:0]  RA1_D,
    input  logic [ADDR-1:0]  RA2_D,
    input  logic [ADDR-1:0]  WA_D,
    input  logic             FlushE,
    input  logic             StallE,
    output logic             Branch_E,
    output logic             MemtoReg_E,
    output logic             MemW_E,
    output logic             ALUSrc_E,
    output logic             RegW_E,
    output logic             ALUOp_E,
    output logic [2:0]       Opcode_E,
    output logic             V_E,
    output logic [2:0]       Funct_E,
    output logic             valid_E,
    output logic [WIDTH-1:0] RD1_E,
    output logic [WIDTH-1:0] RD2_E,
    output logic [WIDTH-1:0] ExtImm_E,
    output logic [ADDR-1:0]  RA1_E,
    output logic [ADDR-1:0]  RA2_E,
    output logic [ADDR-1:0]  WA_E,
    output logic             StallF,
    output logic             StallD,
    output logic [CNT_W-1:0] lost_cycles
);

    typedef struct packed {
        logic             branch;
        logic             mem_to_reg;
        logic             mem_w;
        logic             alu_src;
        logic             reg_w;
        logic             alu_op;
        logic [2:0]       opcode;
        logic             v;
        logic [2:0]       funct;
        logic             valid;
        logic [WIDTH-1:0] rd1;
        logic [WIDTH-1:0] rd2;
        logic [WIDTH-1:0] ext_imm;
        logic [ADDR-1:0]  ra1;
        logic [ADDR-1:0]  ra2;
        logic [ADDR-1:0]  wa;
    } ex_bundle_t;

    ex_bundle_t d_bundle;
    ex_bundle_t ex_q;
    logic       load_use;
    logic       lose_cycle;

    // An invalid decode slot keeps its data but can never cause a side effect.
    always_comb begin
        d_bundle            = '0;
        d_bundle.opcode     = Opcode_D;
        d_bundle.v          = V_D;
        d_bundle.funct      = Funct_D;
        d_bundle.valid      = valid_D;
        d_bundle.rd1        = RD1_D;
        d_bundle.rd2        = RD2_D;
        d_bundle.ext_imm    = ExtImm_D;
        d_bundle.ra1        = RA1_D;
        d_bundle.ra2        = RA2_D;
        d_bundle.wa         = WA_D;
        if (valid_D) begin
            d_bundle.branch     = Branch_D;
            d_bundle.mem_to_reg = MemtoReg_D;
            d_bundle.mem_w      = MemW_D;
            d_bundle.alu_src    = ALUSrc_D;
            d_bundle.reg_w      = RegW_D;
            d_bundle.alu_op     = ALUOp_D;
        end
    end

    assign load_use = ex_q.valid & ex_q.mem_to_reg & ex_q.reg_w & valid_D &
                      ((ex_q.wa == RA1_D) | (ex_q.wa == RA2_D));

    assign StallF     = load_use | StallE;
    assign StallD     = load_use | StallE;
    assign lose_cycle = FlushE | StallE | load_use;

    // Flush beats stall, and stall beats the load-use bubble.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_q <= '0;
        end else if (FlushE) begin
            ex_q <= '0;
        end else if (StallE) begin
            ex_q <= ex_q;
        end else if (load_use) begin
            ex_q <= '0;
        end else begin
            ex_q <= d_bundle;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lost_cycles <= '0;
        end else if (lose_cycle && (lost_cycles != {CNT_W{1'b1}})) begin
            lost_cycles <= lost_cycles + CNT_W'(1);
        end
    end

    assign Branch_E   = ex_q.branch;
    assign MemtoReg_E = ex_q.mem_to_reg;
    assign MemW_E     = ex_q.mem_w;
    assign ALUSrc_E   = ex_q.alu_src;
    assign RegW_E     = ex_q.reg_w;
    assign ALUOp_E    = ex_q.alu_op;
    assign Opcode_E   = ex_q.opcode;
    assign V_E        = ex_q.v;
    assign Funct_E    = ex_q.funct;
    assign valid_E    = ex_q.valid;
    assign RD1_E      = ex_q.rd1;
    assign RD2_E      = ex_q.rd2;
    assign ExtImm_E   = ex_q.ext_imm;
    assign RA1_E      = ex_q.ra1;
    assign RA2_E      = ex_q.ra2;
    assign WA_E       = ex_q.wa;

endmodule

// File: tb/tb_decode_execute_stage.sv
// Directed self-checking bench for decode_execute_stage (counter narrowed
// to 4 bits so saturation is reachable quickly).
module tb_decode_execute_stage;

    localparam int WIDTH = 32;
    localparam int ADDR  = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             Branch_D, MemtoReg_D, MemW_D, ALUSrc_D, RegW_D, ALUOp_D;
    logic [2:0]       Opcode_D, Funct_D;
    logic             V_D, valid_D;
    logic [WIDTH-1:0] RD1_D, RD2_D, ExtImm_D;
    logic [ADDR-1:0]  RA1_D, RA2_D, WA_D;
    logic             FlushE, StallE;
    logic             Branch_E, MemtoReg_E, MemW_E, ALUSrc_E, RegW_E, ALUOp_E;
    logic [2:0]       Opcode_E, Funct_E;
    logic             V_E, valid_E;
    logic [WIDTH-1:0] RD1_E, RD2_E, ExtImm_E;
    logic [ADDR-1:0]  RA1_E, RA2_E, WA_E;
    logic             StallF, StallD;
    logic [CNT_W-1:0] lost_cycles;

    int assertCount = 0;
    int failCount   = 0;

    decode_execute_stage #(.WIDTH(WIDTH), .ADDR(ADDR), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .Branch_D(Branch_D), .MemtoReg_D(MemtoReg_D), .MemW_D(MemW_D),
        .ALUSrc_D(ALUSrc_D), .RegW_D(RegW_D), .ALUOp_D(ALUOp_D),
        .Opcode_D(Opcode_D), .V_D(V_D), .Funct_D(Funct_D), .valid_D(valid_D),
        .RD1_D(RD1_D), .RD2_D(RD2_D), .ExtImm_D(ExtImm_D),
        .RA1_D(RA1_D), .RA2_D(RA2_D), .WA_D(WA_D),
        .FlushE(FlushE), .StallE(StallE),
        .Branch_E(Branch_E), .MemtoReg_E(MemtoReg_E), .MemW_E(MemW_E),
        .ALUSrc_E(ALUSrc_E), .RegW_E(RegW_E), .ALUOp_E(ALUOp_E),
        .Opcode_E(Opcode_E), .V_E(V_E), .Funct_E(Funct_E), .valid_E(valid_E),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .ExtImm_E(ExtImm_E),
        .RA1_E(RA1_E), .RA2_E(RA2_E), .WA_E(WA_E),
        .StallF(StallF), .StallD(StallD), .lost_cycles(lost_cycles)
    );

    always #5 clk = ~clk;

    // Drive the whole decode-side bundle in one call.
    task automatic applyStimulus(
        input logic br, input logic m2r, input logic mw, input logic asrc,
        input logic rw, input logic aop, input logic [2:0] opc, input logic v,
        input logic [2:0] fn, input logic vld,
        input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
        input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa);
        Branch_D = br;  MemtoReg_D = m2r; MemW_D = mw; ALUSrc_D = asrc;
        RegW_D = rw;    ALUOp_D = aop;    Opcode_D = opc; V_D = v;
        Funct_D = fn;   valid_D = vld;
        RD1_D = rd1;    RD2_D = rd2;      ExtImm_D = imm;
        RA1_D = ra1;    RA2_D = ra2;      WA_D = wa;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; FlushE = 1'b0; StallE = 1'b0;
        applyStimulus(0,0,0,1,1,1, 3'd0,0,3'd0,1, 32'h11,32'h0,32'h7, 4'd1,4'd0,4'd3);
        tick();
        checkOutput("reset_valid_E", 32'(valid_E), 32'd0);
        checkOutput("reset_RegW_E", 32'(RegW_E), 32'd0);
        checkOutput("reset_RD1_E", RD1_E, 32'd0);
        checkOutput("reset_lost", 32'(lost_cycles), 32'd0);
        checkOutput("reset_StallD", 32'(StallD), 32'd0);

        // addi WA=3
        rst = 1'b1;
        #1;
        checkOutput("addi_StallD", 32'(StallD), 32'd0);
        tick();
        checkOutput("addi_valid_E", 32'(valid_E), 32'd1);
        checkOutput("addi_RegW_E", 32'(RegW_E), 32'd1);
        checkOutput("addi_ExtImm_E", ExtImm_E, 32'h7);
        checkOutput("addi_WA_E", 32'(WA_E), 32'd3);
        checkOutput("addi_RD1_E", RD1_E, 32'h11);

        // add RA1=3 (no hazard: addi is not a load)
        applyStimulus(0,0,0,0,1,1, 3'd0,0,3'd1,1, 32'h22,32'h33,32'h0, 4'd3,4'd2,4'd4);
        #1;
        checkOutput("add_StallD", 32'(StallD), 32'd0);
        tick();
        checkOutput("add_RA1_E", 32'(RA1_E), 32'd3);
        checkOutput("add_RD2_E", RD2_E, 32'h33);
        checkOutput("add_Funct_E", 32'(Funct_E), 32'd1);
        checkOutput("add_lost", 32'(lost_cycles), 32'd0);

        // ldr WA=5
        applyStimulus(0,1,0,1,1,1, 3'd0,0,3'd0,1, 32'h100,32'h0,32'h4, 4'd1,4'd0,4'd5);
        #1;
        checkOutput("ldr_StallD", 32'(StallD), 32'd0);
        tick();
        checkOutput("ldr_MemtoReg_E", 32'(MemtoReg_E), 32'd1);
        checkOutput("ldr_WA_E", 32'(WA_E), 32'd5);

        // dependent add RA2=5 -> one bubble
        applyStimulus(0,0,0,0,1,1, 3'd0,0,3'd0,1, 32'h44,32'h55,32'h0, 4'd6,4'd5,4'd7);
        #1;
        checkOutput("lu_StallF", 32'(StallF), 32'd1);
        checkOutput("lu_StallD", 32'(StallD), 32'd1);
        tick();
        checkOutput("lu_bubble_valid_E", 32'(valid_E), 32'd0);
        checkOutput("lu_bubble_RegW_E", 32'(RegW_E), 32'd0);
        checkOutput("lu_bubble_MemtoReg_E", 32'(MemtoReg_E), 32'd0);
        checkOutput("lu_bubble_RD1_E", RD1_E, 32'd0);
        checkOutput("lu_lost", 32'(lost_cycles), 32'd1);
        checkOutput("lu_release_StallD", 32'(StallD), 32'd0);
        tick();
        checkOutput("lu_dep_valid_E", 32'(valid_E), 32'd1);
        checkOutput("lu_dep_RA2_E", 32'(RA2_E), 32'd5);
        checkOutput("lu_dep_RD2_E", RD2_E, 32'h55);
        checkOutput("lu_dep_lost", 32'(lost_cycles), 32'd1);

        // flush a valid beq
        applyStimulus(1,0,0,0,0,0, 3'b010,1,3'd0,1, 32'h66,32'h66,32'h10, 4'd1,4'd2,4'd0);
        FlushE = 1'b1;
        tick();
        FlushE = 1'b0;
        checkOutput("flush_valid_E", 32'(valid_E), 32'd0);
        checkOutput("flush_Branch_E", 32'(Branch_E), 32'd0);
        checkOutput("flush_RD1_E", RD1_E, 32'd0);
        checkOutput("flush_Opcode_E", 32'(Opcode_E), 32'd0);
        checkOutput("flush_lost", 32'(lost_cycles), 32'd2);

        // str into EX, then hold 3 cycles
        applyStimulus(0,0,1,1,0,1, 3'd0,0,3'd0,1, 32'h200,32'h77,32'h8, 4'd1,4'd2,4'd0);
        tick();
        checkOutput("str_MemW_E", 32'(MemW_E), 32'd1);
        checkOutput("str_RD2_E", RD2_E, 32'h77);
        applyStimulus(0,0,0,0,1,1, 3'd0,0,3'd0,1, 32'h88,32'h99,32'h0, 4'd9,4'd8,4'd10);
        StallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("stall_StallD", 32'(StallD), 32'd1);
            tick();
            checkOutput("stall_MemW_E", 32'(MemW_E), 32'd1);
            checkOutput("stall_RD2_E", RD2_E, 32'h77);
            checkOutput("stall_ExtImm_E", ExtImm_E, 32'h8);
        end
        StallE = 1'b0;
        checkOutput("stall_lost", 32'(lost_cycles), 32'd5);

        // ldr into EX, then FlushE+StallE+lu together
        applyStimulus(0,1,0,1,1,1, 3'd0,0,3'd0,1, 32'h300,32'h0,32'h4, 4'd1,4'd0,4'd5);
        tick();
        checkOutput("ldr2_valid_E", 32'(valid_E), 32'd1);
        applyStimulus(0,0,0,0,1,1, 3'd0,0,3'd0,1, 32'hAA,32'hBB,32'h0, 4'd5,4'd1,4'd6);
        FlushE = 1'b1; StallE = 1'b1;
        #1;
        checkOutput("combo_StallD", 32'(StallD), 32'd1);
        tick();
        FlushE = 1'b0; StallE = 1'b0;
        checkOutput("combo_valid_E", 32'(valid_E), 32'd0);
        checkOutput("combo_MemtoReg_E", 32'(MemtoReg_E), 32'd0);
        checkOutput("combo_WA_E", 32'(WA_E), 32'd0);
        checkOutput("combo_lost", 32'(lost_cycles), 32'd6);

        // load the add, then reset for one edge mid-stream
        tick();
        checkOutput("pre_reset_valid_E", 32'(valid_E), 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checkOutput("mid_reset_valid_E", 32'(valid_E), 32'd0);
        checkOutput("mid_reset_RA1_E", 32'(RA1_E), 32'd0);
        checkOutput("mid_reset_RegW_E", 32'(RegW_E), 32'd0);
        checkOutput("mid_reset_lost", 32'(lost_cycles), 32'd0);
        checkOutput("mid_reset_StallD", 32'(StallD), 32'd0);

        // invalid slot: data passes, control is gated
        applyStimulus(1,1,1,1,1,1, 3'd5,1,3'd6,0, 32'h99,32'h0,32'h0, 4'd2,4'd3,4'd4);
        tick();
        checkOutput("inv_RegW_E", 32'(RegW_E), 32'd0);
        checkOutput("inv_MemW_E", 32'(MemW_E), 32'd0);
        checkOutput("inv_Branch_E", 32'(Branch_E), 32'd0);
        checkOutput("inv_RD1_E", RD1_E, 32'h99);
        checkOutput("inv_Funct_E", 32'(Funct_E), 32'd6);

        // saturation over 20 stall cycles
        StallE = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) checkOutput("sat_lost_14", 32'(lost_cycles), 32'd14);
            if (i == 15) checkOutput("sat_lost_15", 32'(lost_cycles), 32'd15);
        end
        checkOutput("sat_lost_20", 32'(lost_cycles), 32'd15);
        StallE = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
